// File: rtl/dp_multicycle.sv
`default_nettype none
// dp_multicycle: multi-cycle R-type core (PC, imem, register bank, ALU) sequenced FETCH/DECODE/EXEC/WB.
// Defining DP_PERF_EN enables the 16-bit retired-instruction counter; otherwise retired reads 0.

module dp_rf #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32,
  parameter int AW     = 5
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [AW-1:0]     ra,
  input  logic [AW-1:0]     rb,
  output logic [DATA_W-1:0] rda,
  output logic [DATA_W-1:0] rdb
);
  // Not reset: contents are preloaded externally and must survive rst_n.
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we && (wa != '0)) mem[wa] <= wd;
  end

  assign rda = (ra == '0) ? '0 : mem[ra];
  assign rdb = (rb == '0) ? '0 : mem[rb];
endmodule

module dp_imem #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [31:0]   wd,
  input  logic [AW-1:0] ra,
  output logic [31:0]   rd
);
  logic [31:0] MR [DEPTH];

  always_ff @(posedge clk) begin
    if (we) MR[wa] <= wd;
  end

  assign rd = MR[ra];
endmodule

module dp_multicycle #(
  parameter  int DATA_W     = 32,
  parameter  int REG_DEPTH  = 32,
  parameter  int IMEM_DEPTH = 64,
  localparam int PC_W       = $clog2(IMEM_DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic [DATA_W-1:0] pru,
  output logic [31:0]       prum,
  output logic [PC_W-1:0]   pc,
  output logic              halted,
  output logic [15:0]       retired
);
  localparam int RA_W = (REG_DEPTH > 1) ? $clog2(REG_DEPTH) : 1;

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT} state_t;

  state_t            state;
  logic [DATA_W-1:0] a, b, alu_out, alu_res, rf_a, rf_b;
  logic              wb_valid, alu_legal, rf_we;
  logic [31:0]       im_rd;
  logic [5:0]        op, funct;
  logic [RA_W-1:0]   rs, rt, rd;
  logic              unused_fields;

  assign op    = prum[31:26];
  assign funct = prum[5:0];
  assign rs    = prum[21 +: RA_W];
  assign rt    = prum[16 +: RA_W];
  assign rd    = prum[11 +: RA_W];
  assign unused_fields = ^prum[25:6];

  // Write strobe follows the FSM's WB edge so a stall or reset never produces a partial write.
  assign rf_we = en && (state == S_WB) && wb_valid;

  dp_rf #(.DATA_W(DATA_W), .DEPTH(REG_DEPTH), .AW(RA_W)) u_rf (
    .clk(clk), .we(rf_we), .wa(rd), .wd(alu_out),
    .ra(rs), .rb(rt), .rda(rf_a), .rdb(rf_b)
  );

  dp_imem #(.DEPTH(IMEM_DEPTH), .AW(PC_W)) u_im (
    .clk(clk), .we(1'b0), .wa('0), .wd(32'h0), .ra(pc), .rd(im_rd)
  );

  always_comb begin
    alu_res   = '0;
    alu_legal = 1'b1;
    case (funct)
      6'h20:   alu_res = a + b;
      6'h22:   alu_res = a - b;
      6'h24:   alu_res = a & b;
      6'h25:   alu_res = a | b;
      6'h2A:   alu_res = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
      default: alu_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_FETCH;
      pc       <= '0;
      prum     <= '0;
      a        <= '0;
      b        <= '0;
      alu_out  <= '0;
      wb_valid <= 1'b0;
      pru      <= '0;
      halted   <= 1'b0;
`ifdef DP_PERF_EN
      retired  <= '0;
`endif
    end else if (en && (state != S_HALT)) begin
      case (state)
        S_FETCH: begin
          prum  <= im_rd;
          state <= S_DECODE;
        end
        S_DECODE: begin
          if (op == 6'h3F) begin
            state  <= S_HALT;
            halted <= 1'b1;
          end else begin
            a     <= rf_a;
            b     <= rf_b;
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          alu_out  <= alu_res;
          wb_valid <= alu_legal && (op == 6'h00);
          state    <= S_WB;
        end
        S_WB: begin
          if (wb_valid) pru <= alu_out;
          pc    <= pc + PC_W'(1);
          state <= S_FETCH;
`ifdef DP_PERF_EN
          retired <= retired + 16'd1;
`endif
        end
        default: state <= S_HALT;
      endcase
    end
  end

`ifndef DP_PERF_EN
  assign retired = 16'h0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dp_multicycle.sv
`default_nettype none
// tb_dp_multicycle: vector table, multi-cycle corner sequences and random programs vs an instruction-level model.

module tb_dp_multicycle;
`ifdef DP_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  localparam logic [31:0] HALT_I = 32'hFC000000;
  localparam logic [31:0] SENT   = 32'hDEADBEEF;
  localparam logic [5:0]  FL [7] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h3F, 6'h21};

  logic        clk = 1'b0;
  logic        rst_n, en, rst_n_w, en_w;
  logic [31:0] pru, prum, prum_w;
  logic [5:0]  pc;
  logic [1:0]  pc_w;
  logic [15:0] pru_w, retired, retired_w;
  logic        halted, halted_w;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dp_multicycle dut (
    .clk(clk), .rst_n(rst_n), .en(en), .pru(pru), .prum(prum),
    .pc(pc), .halted(halted), .retired(retired)
  );

  dp_multicycle #(.DATA_W(16), .REG_DEPTH(8), .IMEM_DEPTH(4)) dut_w (
    .clk(clk), .rst_n(rst_n_w), .en(en_w), .pru(pru_w), .prum(prum_w),
    .pc(pc_w), .halted(halted_w), .retired(retired_w)
  );

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  funct;
    logic [31:0] av, bv, exp_rd, exp_pru;
  } vec_t;
  vec_t vt [11];

  logic [31:0] m_rf [32];
  logic [31:0] prog [64];
  logic [31:0] m_pru;
  int          m_pc, m_ret;
  bit          m_halt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs until n cycles with en=1 have elapsed; optionally inserts random stall cycles.
  task automatic run_en(input int n, input bit rnd_en);
    int done = 0;
    int guard = 0;
    while (done < n && guard < 10 * n + 20) begin
      en = rnd_en ? ($urandom_range(0, 3) != 0) : 1'b1;
      tick();
      if (en) done++;
      guard++;
    end
    en = 1'b0;
    chk("run_budget", done, n);
  endtask

  function automatic logic [31:0] rtype(input logic [5:0] op, input logic [5:0] f, input int rd, input int rs, input int rt);
    return {op, 5'(rs), 5'(rt), 5'(rd), 5'd0, f};
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFFFFFF;
      2:       return 32'h80000000;
      3:       return 32'h7FFFFFFF;
      default: return $urandom();
    endcase
  endfunction

  function automatic logic [31:0] rnd_instr();
    logic [5:0] op;
    op = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(1, 62)) : 6'h00;
    return {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 31)), FL[$urandom_range(0, 6)]};
  endfunction

  // Instruction-level interpretation of the program: one loop iteration per instruction.
  task automatic model_run();
    logic [31:0] ins, x, y, r;
    bit ok;
    m_pru = 0; m_pc = 0; m_ret = 0; m_halt = 0;
    for (int s = 0; s < 64 && !m_halt; s++) begin
      ins = prog[m_pc];
      if (ins[31:26] == 6'h3F) begin
        m_halt = 1;
      end else begin
        x  = (ins[25:21] == 0) ? 32'h0 : m_rf[ins[25:21]];
        y  = (ins[20:16] == 0) ? 32'h0 : m_rf[ins[20:16]];
        ok = (ins[31:26] == 6'h00);
        r  = 32'h0;
        case (ins[5:0])
          6'h20:   r = x + y;
          6'h22:   r = x - y;
          6'h24:   r = x & y;
          6'h25:   r = x | y;
          6'h2A:   r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
          default: ok = 0;
        endcase
        if (ok) begin
          m_pru = r;
          if (ins[15:11] != 0) m_rf[ins[15:11]] = r;
        end
        m_pc = (m_pc + 1) % 64;
        m_ret++;
      end
    end
  endtask

  initial begin
    rst_n = 1'b1; en = 1'b0; rst_n_w = 1'b1; en_w = 1'b0;
    #1;
    rst_n = 1'b0; rst_n_w = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rst_pc", pc, 0);
    chk("rst_pru", pru, 0);
    chk("rst_prum", prum, 0);
    chk("rst_halted", halted, 0);
    chk("rst_retired", retired, 0);

    // Single-instruction vectors: rs=r1, rt=r2, rd=r3.
    vt[0]  = '{6'h00, 6'h20, 32'd7, 32'd5, 32'd12, 32'd12};
    vt[1]  = '{6'h00, 6'h22, 32'd7, 32'd5, 32'd2, 32'd2};
    vt[2]  = '{6'h00, 6'h20, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0};
    vt[3]  = '{6'h00, 6'h2A, 32'hFFFFFFFF, 32'd1, 32'd1, 32'd1};
    vt[4]  = '{6'h00, 6'h2A, 32'd1, 32'hFFFFFFFF, 32'd0, 32'd0};
    vt[5]  = '{6'h00, 6'h24, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 32'hF000F000};
    vt[6]  = '{6'h00, 6'h25, 32'h0F0F0000, 32'hF000000F, 32'hFF0F000F, 32'hFF0F000F};
    vt[7]  = '{6'h00, 6'h22, 32'd0, 32'd1, 32'hFFFFFFFF, 32'hFFFFFFFF};
    vt[8]  = '{6'h00, 6'h3F, 32'd7, 32'd5, SENT, 32'd0};
    vt[9]  = '{6'h05, 6'h20, 32'd7, 32'd5, SENT, 32'd0};
    vt[10] = '{6'h00, 6'h2A, 32'h80000000, 32'h7FFFFFFF, 32'd1, 32'd1};
    for (int i = 0; i < 11; i++) begin
      rst_n = 1'b0;
      dut.u_rf.mem[1] = vt[i].av;
      dut.u_rf.mem[2] = vt[i].bv;
      dut.u_rf.mem[3] = SENT;
      dut.u_im.MR[0] = rtype(vt[i].op, vt[i].funct, 3, 1, 2);
      tick();
      rst_n = 1'b1;
      run_en(4, 1'b0);
      chk($sformatf("vec%0d_r3", i), dut.u_rf.mem[3], vt[i].exp_rd);
      chk($sformatf("vec%0d_pru", i), pru, vt[i].exp_pru);
      chk($sformatf("vec%0d_pc", i), pc, 1);
    end

    // r0 sink: pru still updates, r0 keeps reading 0.
    rst_n = 1'b0;
    dut.u_rf.mem[1] = 32'd7; dut.u_rf.mem[2] = 32'd5; dut.u_rf.mem[3] = SENT;
    dut.u_im.MR[0] = rtype(6'h00, 6'h20, 0, 1, 2);
    dut.u_im.MR[1] = rtype(6'h00, 6'h25, 3, 0, 0);
    tick();
    rst_n = 1'b1;
    run_en(4, 1'b0);
    chk("r0_pru", pru, 12);
    run_en(4, 1'b0);
    chk("r0_reads_zero", dut.u_rf.mem[3], 0);
    chk("r0_pru2", pru, 0);

    // Arith sequence then asynchronous reset in the middle of EXEC.
    rst_n = 1'b0;
    dut.u_rf.mem[1] = 32'd7; dut.u_rf.mem[2] = 32'd5; dut.u_rf.mem[5] = 32'h55;
    dut.u_rf.mem[3] = SENT; dut.u_rf.mem[4] = SENT;
    dut.u_im.MR[0] = rtype(6'h00, 6'h20, 3, 1, 2);
    dut.u_im.MR[1] = rtype(6'h00, 6'h22, 4, 1, 2);
    tick();
    rst_n = 1'b1;
    run_en(8, 1'b0);
    chk("arith_r3", dut.u_rf.mem[3], 12);
    chk("arith_r4", dut.u_rf.mem[4], 2);
    chk("arith_pru", pru, 2);
    chk("arith_pc", pc, 2);
    rst_n = 1'b0;
    dut.u_rf.mem[4] = SENT;
    tick();
    rst_n = 1'b1;
    run_en(6, 1'b0);
    chk("pre_rst_pc", pc, 1);
    chk("pre_rst_pru", pru, 12);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_pc", pc, 0);
    chk("async_pru", pru, 0);
    chk("async_prum", prum, 0);
    chk("async_halted", halted, 0);
    tick(); tick();
    rst_n = 1'b1;
    chk("rst_r4_untouched", dut.u_rf.mem[4], SENT);
    chk("rst_r5_preload", dut.u_rf.mem[5], 32'h55);

    // Stall in DECODE, then HALT at pc=3.
    rst_n = 1'b0;
    dut.u_rf.mem[4] = SENT; dut.u_rf.mem[5] = SENT;
    dut.u_im.MR[2] = rtype(6'h00, 6'h25, 5, 1, 2);
    dut.u_im.MR[3] = HALT_I;
    tick();
    rst_n = 1'b1;
    run_en(5, 1'b0);
    en = 1'b0;
    repeat (5) tick();
    chk("stall_pc", pc, 1);
    chk("stall_pru", pru, 12);
    chk("stall_prum", prum, rtype(6'h00, 6'h22, 4, 1, 2));
    chk("stall_r4", dut.u_rf.mem[4], SENT);
    run_en(3, 1'b0);
    chk("resume_r4", dut.u_rf.mem[4], 2);
    chk("resume_pru", pru, 2);
    run_en(4, 1'b0);
    chk("or_r5", dut.u_rf.mem[5], 7);
    run_en(2, 1'b0);
    chk("halt_flag", halted, 1);
    for (int i = 0; i < 20; i++) begin
      en = 1'($urandom_range(0, 1));
      tick();
      chk($sformatf("halt_pc_%0d", i), pc, 3);
    end
    en = 1'b0;
    chk("halt_pru", pru, 7);
    chk("halt_prum", prum, HALT_I);
    chk("halt_retired", retired, PERF ? 3 : 0);

    // Five retirements (including NOPs) before HALT.
    rst_n = 1'b0;
    dut.u_im.MR[0] = rtype(6'h00, 6'h20, 6, 1, 2);
    dut.u_im.MR[1] = rtype(6'h07, 6'h20, 6, 1, 2);
    dut.u_im.MR[2] = rtype(6'h00, 6'h3F, 6, 1, 2);
    dut.u_im.MR[3] = rtype(6'h00, 6'h24, 6, 1, 2);
    dut.u_im.MR[4] = rtype(6'h00, 6'h22, 6, 1, 2);
    dut.u_im.MR[5] = HALT_I;
    tick();
    rst_n = 1'b1;
    run_en(24, 1'b0);
    chk("perf_retired", retired, PERF ? 5 : 0);
    chk("perf_pc", pc, 5);
    chk("perf_halted", halted, 1);

    // PC wrap on a 4-word imem, all NOP forms.
    rst_n_w = 1'b0;
    dut_w.u_rf.mem[1] = 16'd7; dut_w.u_rf.mem[2] = 16'd5; dut_w.u_rf.mem[3] = 16'hBEEF;
    dut_w.u_im.MR[0] = rtype(6'h00, 6'h3F, 3, 1, 2);
    dut_w.u_im.MR[1] = rtype(6'h01, 6'h20, 3, 1, 2);
    dut_w.u_im.MR[2] = rtype(6'h00, 6'h3F, 3, 1, 2);
    dut_w.u_im.MR[3] = rtype(6'h00, 6'h21, 3, 1, 2);
    tick();
    rst_n_w = 1'b1;
    chk("wrap_pc0", pc_w, 0);
    en_w = 1'b1;
    for (int j = 1; j <= 5; j++) begin
      repeat (4) tick();
      chk($sformatf("wrap_pc_step%0d", j), pc_w, j % 4);
    end
    en_w = 1'b0;
    chk("wrap_r3", dut_w.u_rf.mem[3], 16'hBEEF);
    chk("wrap_pru", pru_w, 0);
    chk("wrap_retired", retired_w, PERF ? 5 : 0);

    // Random programs with random stalls.
    for (int t = 0; t < 40; t++) begin
      int k, extra;
      k = $urandom_range(1, 10);
      extra = $urandom_range(0, 6);
      rst_n = 1'b0;
      for (int i = 0; i < 32; i++) begin
        m_rf[i] = pick();
        dut.u_rf.mem[i] = m_rf[i];
      end
      for (int i = 0; i < k; i++) prog[i] = rnd_instr();
      prog[k] = HALT_I;
      for (int i = 0; i <= k; i++) dut.u_im.MR[i] = prog[i];
      tick();
      rst_n = 1'b1;
      model_run();
      run_en(4 * k + 2 + extra, 1'b1);
      for (int i = 1; i < 8; i++) chk($sformatf("rnd%0d_r%0d", t, i), dut.u_rf.mem[i], m_rf[i]);
      chk($sformatf("rnd%0d_pru", t), pru, m_pru);
      chk($sformatf("rnd%0d_pc", t), pc, m_pc);
      chk($sformatf("rnd%0d_halted", t), halted, 1);
      chk($sformatf("rnd%0d_retired", t), retired, PERF ? m_ret : 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
